coin_input_conditioner: RTL and testbench

//  Front end of the vending machine; sits directly upstream of the vending FSM.

---
 rtl/vend_pkg.sv | 57 +++++
 rtl/input_debouncer.sv | 64 ++++++
 rtl/coin_input_conditioner.sv | 162 ++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin channel indices, coin values,
// the coin-arbiter state encoding and small helpers used by the input front end.
package vend_pkg;

   // Coin channels
   localparam int unsigned NUM_COINS = 3;
   localparam int unsigned CH_W      = 2;

   localparam logic [CH_W-1:0] CH_N = 2'd0;
   localparam logic [CH_W-1:0] CH_D = 2'd1;
   localparam logic [CH_W-1:0] CH_Q = 2'd2;

   // Coin values in cents, shared with the vending FSM
   localparam int unsigned COIN_VAL_W    = 5;
   localparam int unsigned NICKEL_VALUE  = 5;
   localparam int unsigned DIME_VALUE    = 10;
   localparam int unsigned QUARTER_VALUE = 25;

   // Coin arbiter states
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_PULSE = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_e;

   // Highest-priority pending channel, Q > D > N (caller guarantees |pend)
   function automatic logic [CH_W-1:0] pick_coin(input logic [NUM_COINS-1:0] pend);
      logic [CH_W-1:0] ch;
      if (pend[CH_Q])      ch = CH_Q;
      else if (pend[CH_D]) ch = CH_D;
      else                 ch = CH_N;
      return ch;
   endfunction

   // One-hot mask for a channel index
   function automatic logic [NUM_COINS-1:0] ch_onehot(input logic [CH_W-1:0] ch);
      logic [NUM_COINS-1:0] mask;
      mask = '0;
      for (int i = 0; i < int'(NUM_COINS); i++) begin
         if (ch == CH_W'(i)) mask[i] = 1'b1;
      end
      return mask;
   endfunction

   // Cent value of a channel
   function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [CH_W-1:0] ch);
      logic [COIN_VAL_W-1:0] val;
      case (ch)
         CH_N:    val = COIN_VAL_W'(NICKEL_VALUE);
         CH_D:    val = COIN_VAL_W'(DIME_VALUE);
         CH_Q:    val = COIN_VAL_W'(QUARTER_VALUE);
         default: val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Synchronise and debounce one asynchronous active-high input.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-low reset
//   raw    in  asynchronous raw input
//   deb    out debounced level (changes after DEBOUNCE_CYCLES stable samples)
//   rise   out one-cycle pulse registered on the edge deb goes 0->1
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic deb,
   output logic rise
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q,   s1_d;
   logic             s2_q,   s2_d;
   logic             deb_q,  deb_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;

   // Stability counter: runs while the synchronised sample disagrees with deb,
   // and the level flips on the edge where the count would reach DEBOUNCE_CYCLES.
   always_comb begin
      s1_d   = raw;
      s2_d   = s1_q;
      deb_d  = deb_q;
      cnt_d  = '0;
      rise_d = 1'b0;
      if (s2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d  = s2_q;
            rise_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         deb_q  <= 1'b0;
         rise_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         deb_q  <= deb_d;
         rise_q <= rise_d;
         cnt_q  <= cnt_d;
      end
   end

   assign deb  = deb_q;
   assign rise = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Vending-machine input front end: debounces coin sensors and select buttons,
// turns every coin insertion into one single-cycle N_in/D_in/Q_in pulse with a
// forced idle gap between pulses, and presents clean drink-select levels.
// Ports:
//   clk, reset                       clock / synchronous active-low reset
//   nickel_raw, dime_raw, quarter_raw  async coin-slot sensors
//   diet_btn_raw, soda_btn_raw         async select buttons
//   N_in, D_in, Q_in                   registered one-cycle coin pulses
//   diet_in, soda_in                   debounced, mutually exclusive select levels
//   coin_busy                          any coin pending or arbiter not idle
//   overflow_err                       sticky: coin lost on an already-pending channel
module coin_input_conditioner
   import vend_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES      = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic nickel_raw,
   input  logic dime_raw,
   input  logic quarter_raw,
   input  logic diet_btn_raw,
   input  logic soda_btn_raw,
   output logic N_in,
   output logic D_in,
   output logic Q_in,
   output logic diet_in,
   output logic soda_in,
   output logic coin_busy,
   output logic overflow_err
);

   localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   logic [NUM_COINS-1:0] coin_raw;
   logic [NUM_COINS-1:0] coin_deb;
   logic [NUM_COINS-1:0] coin_rise;
   logic                 diet_deb, diet_rise;
   logic                 soda_deb, soda_rise;
   logic                 unused_deb_bits;

   arb_state_e           state_q,   state_d;
   logic [CH_W-1:0]      sel_q,     sel_d;
   logic [NUM_COINS-1:0] pend_q,    pend_d;
   logic [NUM_COINS-1:0] pulse_q,   pulse_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic                 busy_q,    busy_d;
   logic                 ovf_q,     ovf_d;
   logic [NUM_COINS-1:0] clr;
   logic                 launch_ok;

   assign coin_raw[CH_N] = nickel_raw;
   assign coin_raw[CH_D] = dime_raw;
   assign coin_raw[CH_Q] = quarter_raw;

   // Five identical conditioning channels
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
      .clk(clk), .reset(reset), .raw(coin_raw[CH_N]),
      .deb(coin_deb[CH_N]), .rise(coin_rise[CH_N]));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
      .clk(clk), .reset(reset), .raw(coin_raw[CH_D]),
      .deb(coin_deb[CH_D]), .rise(coin_rise[CH_D]));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_q (
      .clk(clk), .reset(reset), .raw(coin_raw[CH_Q]),
      .deb(coin_deb[CH_Q]), .rise(coin_rise[CH_Q]));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_diet (
      .clk(clk), .reset(reset), .raw(diet_btn_raw),
      .deb(diet_deb), .rise(diet_rise));
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_soda (
      .clk(clk), .reset(reset), .raw(soda_btn_raw),
      .deb(soda_deb), .rise(soda_rise));

   // Coins only need edges and buttons only need levels
   assign unused_deb_bits = ^{coin_deb, diet_rise, soda_rise};

   // Pending flags, overflow detection and the coin arbiter.
   // A new launch may be decided in IDLE, on the last GAP cycle, or straight
   // out of PULSE when there is no gap, so pulses land exactly GAP_CYCLES+1 apart.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      gap_cnt_d = gap_cnt_q;
      pulse_d   = '0;
      clr       = '0;
      launch_ok = 1'b0;

      if (state_q == ARB_PULSE) clr = ch_onehot(sel_q);

      // Set wins over clear on the same channel
      pend_d = (pend_q & ~clr) | coin_rise;
      ovf_d  = ovf_q | (|(coin_rise & pend_q & ~clr));

      case (state_q)
         ARB_IDLE: begin
            launch_ok = 1'b1;
         end
         ARB_PULSE: begin
            if (GAP_CYCLES == 0) begin
               launch_ok = 1'b1;
            end else begin
               state_d   = ARB_GAP;
               gap_cnt_d = '0;
            end
         end
         ARB_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
               launch_ok = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (launch_ok) begin
         if (|pend_d) begin
            state_d = ARB_PULSE;
            sel_d   = pick_coin(pend_d);
            pulse_d = ch_onehot(sel_d);
         end else begin
            state_d = ARB_IDLE;
         end
      end

      busy_d = (|pend_d) || (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ARB_IDLE;
         sel_q     <= CH_N;
         pend_q    <= '0;
         pulse_q   <= '0;
         gap_cnt_q <= '0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         pend_q    <= pend_d;
         pulse_q   <= pulse_d;
         gap_cnt_q <= gap_cnt_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   assign N_in         = pulse_q[CH_N];
   assign D_in         = pulse_q[CH_D];
   assign Q_in         = pulse_q[CH_Q];
   assign coin_busy    = busy_q;
   assign overflow_err = ovf_q;

   // Both buttons held means no valid selection
   assign diet_in = diet_deb & ~soda_deb;
   assign soda_in = soda_deb & ~diet_deb;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner: one instance with the default
// gap and one with a long gap for overflow and reset-during-gap behaviour.
module tb_coin_input_conditioner;

   logic clk;
   logic reset;

   logic n_raw, d_raw, q_raw, diet_raw, soda_raw;
   logic n_in, d_in, q_in, diet_in, soda_in, busy, ovf;

   logic gn_raw, gd_raw, gq_raw, gdiet_raw, gsoda_raw;
   logic gn_in, gd_in, gq_in, gdiet_in, gsoda_in, gbusy, govf;

   int passed;
   int total;
   int n_cnt, d_cnt, q_cnt;
   int gn_cnt, gd_cnt, gq_cnt;
   logic busy_seen;
   logic multi_seen;

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .nickel_raw(n_raw), .dime_raw(d_raw), .quarter_raw(q_raw),
      .diet_btn_raw(diet_raw), .soda_btn_raw(soda_raw),
      .N_in(n_in), .D_in(d_in), .Q_in(q_in),
      .diet_in(diet_in), .soda_in(soda_in),
      .coin_busy(busy), .overflow_err(ovf));

   coin_input_conditioner #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(12)) dut_g (
      .clk(clk), .reset(reset),
      .nickel_raw(gn_raw), .dime_raw(gd_raw), .quarter_raw(gq_raw),
      .diet_btn_raw(gdiet_raw), .soda_btn_raw(gsoda_raw),
      .N_in(gn_in), .D_in(gd_in), .Q_in(gq_in),
      .diet_in(gdiet_in), .soda_in(gsoda_in),
      .coin_busy(gbusy), .overflow_err(govf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge and tally observed pulses
   task automatic tick();
      @(posedge clk);
      #1;
      n_cnt  = n_cnt  + int'(n_in);
      d_cnt  = d_cnt  + int'(d_in);
      q_cnt  = q_cnt  + int'(q_in);
      gn_cnt = gn_cnt + int'(gn_in);
      gd_cnt = gd_cnt + int'(gd_in);
      gq_cnt = gq_cnt + int'(gq_in);
      if (busy) busy_seen = 1'b1;
      if ((int'(n_in) + int'(d_in) + int'(q_in)) > 1) multi_seen = 1'b1;
      if ((int'(gn_in) + int'(gd_in) + int'(gq_in)) > 1) multi_seen = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic clear_counts();
      n_cnt = 0; d_cnt = 0; q_cnt = 0;
      gn_cnt = 0; gd_cnt = 0; gq_cnt = 0;
      busy_seen = 1'b0;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      multi_seen = 1'b0;
      clear_counts();
      reset = 1'b0;
      n_raw = 0; d_raw = 0; q_raw = 0; diet_raw = 0; soda_raw = 0;
      gn_raw = 0; gd_raw = 0; gq_raw = 0; gdiet_raw = 0; gsoda_raw = 0;

      // 1: reset held for two edges
      tick(); tick();
      chk("rst_outputs", {2'b00, n_in, d_in, q_in, diet_in, soda_in, 1'b0}, 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_ovf", 8'(ovf), 8'h00);
      chk("rst_g_outputs", {1'b0, gn_in, gd_in, gq_in, gdiet_in, gsoda_in, gbusy, govf}, 8'h00);
      reset = 1'b1;
      repeat (3) tick();

      // 2: clean nickel, 8 cycles
      clear_counts();
      n_raw = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (e == 5) chk("t2_n_edge5", 8'(n_in), 8'h00);
         if (e == 6) begin
            chk("t2_n_edge6", 8'(n_in), 8'h01);
            chk("t2_dq_edge6", {6'b0, d_in, q_in}, 8'h00);
            chk("t2_busy_edge6", 8'(busy), 8'h01);
         end
         if (e == 7) chk("t2_n_edge7", 8'(n_in), 8'h00);
      end
      n_raw = 1'b0;
      repeat (12) tick();
      chk("t2_n_count", 8'(n_cnt), 8'h01);
      chk("t2_dq_count", 8'(d_cnt + q_cnt), 8'h00);
      chk("t2_busy_idle", 8'(busy), 8'h00);

      // 3: 3-cycle dime glitch is rejected
      clear_counts();
      d_raw = 1'b1;
      repeat (3) tick();
      d_raw = 1'b0;
      repeat (15) tick();
      chk("t3_d_count", 8'(d_cnt), 8'h00);
      chk("t3_busy_seen", 8'(busy_seen), 8'h00);

      // 4: quarter and nickel together, quarter wins, nickel 3 cycles later
      clear_counts();
      q_raw = 1'b1;
      n_raw = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         if (e == 6) chk("t4_qn_edge6", {6'b0, q_in, n_in}, 8'h02);
         if (e == 7) chk("t4_qn_edge7", {6'b0, q_in, n_in}, 8'h00);
         if (e == 8) chk("t4_qn_edge8", {6'b0, q_in, n_in}, 8'h00);
         if (e == 9) chk("t4_qn_edge9", {6'b0, q_in, n_in}, 8'h01);
         if (e == 7) begin
            q_raw = 1'b0;
            n_raw = 1'b0;
         end
      end
      repeat (10) tick();
      chk("t4_counts", {4'(q_cnt), 4'(n_cnt)}, 8'h11);
      chk("t4_d_count", 8'(d_cnt), 8'h00);

      // 5: button levels and mutual exclusion
      diet_raw = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 4) chk("t5_diet_edge4", {6'b0, diet_in, soda_in}, 8'h00);
         if (e == 5) chk("t5_diet_edge5", {6'b0, diet_in, soda_in}, 8'h02);
      end
      soda_raw = 1'b1;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 4) chk("t5_both_edge4", {6'b0, diet_in, soda_in}, 8'h02);
         if (e == 5) chk("t5_both_edge5", {6'b0, diet_in, soda_in}, 8'h00);
      end
      diet_raw = 1'b0;
      for (int e = 0; e < 6; e++) begin
         tick();
         if (e == 5) chk("t5_soda_only", {6'b0, diet_in, soda_in}, 8'h01);
      end
      soda_raw = 1'b0;
      repeat (8) tick();
      chk("t5_released", {6'b0, diet_in, soda_in}, 8'h00);

      // 6: long gap, dime re-inserted while pending, then reset mid-gap
      clear_counts();
      gq_raw = 1'b1;
      gd_raw = 1'b1;
      gn_raw = 1'b1;
      for (int e = 0; e < 60; e++) begin
         tick();
         if (e == 6)  chk("t6_q_edge6", {5'b0, gq_in, gd_in, gn_in}, 8'h04);
         if (e == 16) chk("t6_ovf_edge16", 8'(govf), 8'h00);
         if (e == 17) begin
            chk("t6_ovf_edge17", 8'(govf), 8'h01);
            chk("t6_d_not_yet", 8'(gd_cnt), 8'h00);
         end
         if (e == 18) chk("t6_d_edge18", 8'(gd_in), 8'h00);
         if (e == 19) chk("t6_d_edge19", {5'b0, gq_in, gd_in, gn_in}, 8'h02);
         if (e == 23) begin
            chk("t6_rst_outputs", {3'b0, gn_in, gd_in, gq_in, gbusy, govf}, 8'h00);
            chk("t6_rst_other", {4'b0, n_in, d_in, q_in, busy}, 8'h00);
         end
         if (e == 5) gd_raw = 1'b0;
         if (e == 7) begin
            gq_raw = 1'b0;
            gn_raw = 1'b0;
         end
         if (e == 10) gd_raw = 1'b1;
         if (e == 22) begin
            gd_raw = 1'b0;
            reset  = 1'b0;
         end
         if (e == 24) reset = 1'b1;
      end
      chk("t6_counts", {2'b0, 2'(gq_cnt), 2'(gd_cnt), 2'(gn_cnt)}, 8'h14);
      chk("t6_ovf_after", 8'(govf), 8'h00);
      chk("t6_busy_after", 8'(gbusy), 8'h00);

      chk("one_hot_pulses", 8'(multi_seen), 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
